// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode/state types for the universal shift register
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHR  = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_LOAD = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } usr_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_e;

    // Only modes that move bits are meaningful to repeat as a burst
    function automatic logic is_burst_mode(input logic [2:0] m);
        case (usr_mode_e'(m))
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: is_burst_mode = 1'b1;
            default:                                          is_burst_mode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usr_shift_core.sv
// rtl/usr_shift_core.sv - combinational next-value mux shared by direct and burst paths
module usr_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p_din,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic [WIDTH-1:0] d
);

    always_comb begin
        d = q;
        case (usr_mode_e'(mode))
            MODE_SHR:  d = {ser_in_msb, q[WIDTH-1:1]};
            MODE_SHL:  d = {q[WIDTH-2:0], ser_in_lsb};
            MODE_LOAD: d = p_din;
            MODE_ROR:  d = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  d = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  d = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   d = q;
        endcase
    end

endmodule

// File: rtl/usr_param.sv
// rtl/usr_param.sv - universal shift register with burst engine; USR_PARITY_EN adds parity output
module usr_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p_din,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] p_dout,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    usr_state_e       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [2:0]       mode_q, mode_q_nxt;
    logic [WIDTH-1:0] q, q_nxt, core_d;
    logic             done_nxt;
    logic             valid_start;
    logic [2:0]       core_mode;

    assign core_mode = (state == ST_RUN) ? mode_q : mode;

    usr_shift_core #(.WIDTH(WIDTH)) u_core (
        .q          (q),
        .mode       (core_mode),
        .p_din      (p_din),
        .ser_in_msb (ser_in_msb),
        .ser_in_lsb (ser_in_lsb),
        .d          (core_d)
    );

    assign valid_start = start && (burst_len != '0) && is_burst_mode(mode);

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        mode_q_nxt = mode_q;
        q_nxt      = q;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A valid start only arms the engine; the register moves from the next edge
                if (valid_start) begin
                    state_nxt  = ST_RUN;
                    count_nxt  = burst_len;
                    mode_q_nxt = mode;
                end else if (en) begin
                    q_nxt = core_d;
                end
            end
            ST_RUN: begin
                q_nxt     = core_d;
                count_nxt = count - 1'b1;
                if (count == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            mode_q <= MODE_HOLD;
            q      <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            mode_q <= mode_q_nxt;
            q      <= q_nxt;
            done   <= done_nxt;
        end
    end

`ifdef USR_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) parity <= 1'b0;
        else      parity <= ^q_nxt;
    end
`endif

    assign p_dout      = q;
    assign ser_out_lsb = q[0];
    assign ser_out_msb = q[WIDTH-1];
    assign busy        = (state == ST_RUN);

endmodule

// File: tb/tb_usr_param.sv
// tb/tb_usr_param.sv - directed self-checking bench for usr_param (WIDTH=8, CNT_W=4)
module tb_usr_param;

    logic       clk = 1'b0;
    logic       rst, en, ser_in_msb, ser_in_lsb, start;
    logic [2:0] mode;
    logic [7:0] p_din;
    logic [3:0] burst_len;
    logic [7:0] p_dout;
    logic       ser_out_lsb, ser_out_msb, busy, done;
`ifdef USR_PARITY_EN
    logic       parity;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    usr_param #(.WIDTH(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .p_din       (p_din),
        .ser_in_msb  (ser_in_msb),
        .ser_in_lsb  (ser_in_lsb),
        .start       (start),
        .burst_len   (burst_len),
        .p_dout      (p_dout),
        .ser_out_lsb (ser_out_lsb),
        .ser_out_msb (ser_out_msb),
        .busy        (busy),
        .done        (done)
`ifdef USR_PARITY_EN
        ,
        .parity      (parity)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] m, input logic [7:0] d);
        en = 1'b1; mode = m; p_din = d; start = 1'b0;
        tick();
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; mode = 3'd3; p_din = 8'hFF;
        start = 1'b0; burst_len = 4'd0; ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
        tick(); tick();
        tests++; if (p_dout !== 8'h00) begin fails++; $display("FAIL reset_dout got %h want 00", p_dout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b1; en = 1'b0;
    endtask

    task automatic test_direct();
        do_op(3'd3, 8'hA5);
        tests++; if (p_dout !== 8'hA5) begin fails++; $display("FAIL load_a5 got %h want a5", p_dout); end
        ser_in_msb = 1'b1; do_op(3'd1, 8'h00);
        tests++; if (p_dout !== 8'hD2) begin fails++; $display("FAIL shr got %h want d2", p_dout); end
        tests++; if ({ser_out_msb, ser_out_lsb} !== 2'b10) begin fails++; $display("FAIL ser_out got %b want 10", {ser_out_msb, ser_out_lsb}); end
        ser_in_lsb = 1'b0; do_op(3'd2, 8'h00);
        tests++; if (p_dout !== 8'hA4) begin fails++; $display("FAIL shl got %h want a4", p_dout); end
        do_op(3'd3, 8'h96); do_op(3'd6, 8'h00);
        tests++; if (p_dout !== 8'hCB) begin fails++; $display("FAIL asr got %h want cb", p_dout); end
        do_op(3'd3, 8'h81); do_op(3'd4, 8'h00);
        tests++; if (p_dout !== 8'hC0) begin fails++; $display("FAIL ror got %h want c0", p_dout); end
        do_op(3'd3, 8'h81); do_op(3'd5, 8'h00);
        tests++; if (p_dout !== 8'h03) begin fails++; $display("FAIL rol got %h want 03", p_dout); end
        do_op(3'd7, 8'hFF);
        tests++; if (p_dout !== 8'h03) begin fails++; $display("FAIL rsvd_hold got %h want 03", p_dout); end
        en = 1'b0; mode = 3'd1; tick();
        tests++; if (p_dout !== 8'h03) begin fails++; $display("FAIL en0_hold got %h want 03", p_dout); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h02; exp_v[1] = 8'h04; exp_v[2] = 8'h08;
        do_op(3'd3, 8'h01);
        en = 1'b1; start = 1'b1; mode = 3'd5; burst_len = 4'd3;
        tick();
        tests++; if ({busy, done, p_dout} !== {2'b10, 8'h01}) begin fails++; $display("FAIL burst_arm got b%b d%b %h want b1 d0 01", busy, done, p_dout); end
        // Direct-path inputs must be ignored while running
        start = 1'b0; mode = 3'd3; p_din = 8'hFF; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (p_dout !== exp_v[i] || busy !== (i < 2) || done !== (i == 2)) begin
                fails++;
                $display("FAIL burst_step%0d got %h b%b d%b want %h b%b d%b", i, p_dout, busy, done, exp_v[i], i < 2, i == 2);
            end
        end
        en = 1'b0; tick();
        tests++; if ({busy, done, p_dout} !== {2'b00, 8'h08}) begin fails++; $display("FAIL burst_after got b%b d%b %h want b0 d0 08", busy, done, p_dout); end
    endtask

    task automatic test_ignored_start();
        int n_done = 0;
        en = 1'b0; start = 1'b1; mode = 3'd5; burst_len = 4'd0;
        tick();
        tests++; if (busy !== 1'b0 || p_dout !== 8'h08) begin fails++; $display("FAIL len0_start got b%b %h want b0 08", busy, p_dout); end
        en = 1'b1; mode = 3'd3; p_din = 8'h5A; burst_len = 4'd3;
        tick();
        tests++; if (busy !== 1'b0 || p_dout !== 8'h5A) begin fails++; $display("FAIL load_start got b%b %h want b0 5a", busy, p_dout); end
        do_op(3'd3, 8'h01);
        start = 1'b1; mode = 3'd5; burst_len = 4'd2;
        tick();
        burst_len = 4'd4;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done) n_done++;
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) n_done++;
        end
        tests++; if (n_done !== 1) begin fails++; $display("FAIL midburst_done_count got %0d want 1", n_done); end
        tests++; if (p_dout !== 8'h04 || busy !== 1'b0) begin fails++; $display("FAIL midburst_final got %h b%b want 04 b0", p_dout, busy); end
    endtask

    task automatic test_abort();
        int n_done = 0;
        do_op(3'd3, 8'h01);
        ser_in_lsb = 1'b0; start = 1'b1; mode = 3'd2; burst_len = 4'd5;
        tick();
        start = 1'b0;
        tick(); tick();
        tests++; if (p_dout !== 8'h04 || busy !== 1'b1) begin fails++; $display("FAIL abort_pre got %h b%b want 04 b1", p_dout, busy); end
        rst = 1'b0; tick(); rst = 1'b1;
        tests++; if ({busy, done, p_dout} !== {2'b00, 8'h00}) begin fails++; $display("FAIL abort_rst got b%b d%b %h want b0 d0 00", busy, done, p_dout); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) n_done++;
        end
        tests++; if (n_done !== 0 || p_dout !== 8'h00) begin fails++; $display("FAIL abort_after got %0d activity %h want 0 00", n_done, p_dout); end
    endtask

    task automatic test_serial_live();
        // Serial input is sampled on every burst edge, not latched at start
        do_op(3'd3, 8'h00);
        start = 1'b1; mode = 3'd1; burst_len = 4'd3; ser_in_msb = 1'b1;
        tick();
        start = 1'b0;
        tick(); ser_in_msb = 1'b0; tick(); ser_in_msb = 1'b1; tick();
        tests++; if (p_dout !== 8'hA0 || done !== 1'b1) begin fails++; $display("FAIL serial_live got %h d%b want a0 d1", p_dout, done); end
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity();
        do_op(3'd3, 8'h07);
        tests++; if (parity !== 1'b1) begin fails++; $display("FAIL parity_07 got %b want 1", parity); end
        ser_in_lsb = 1'b0; do_op(3'd2, 8'h00);
        tests++; if (p_dout !== 8'h0E || parity !== 1'b1) begin fails++; $display("FAIL parity_0e got %h %b want 0e 1", p_dout, parity); end
        do_op(3'd3, 8'h03);
        tests++; if (parity !== 1'b0) begin fails++; $display("FAIL parity_03 got %b want 0", parity); end
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
        test_burst();
        test_ignored_start();
        test_abort();
        test_serial_live();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
